// File: rtl/wb2av_bridge.sv
// Wishbone B3 classic slave to Avalon-MM pipelined master bridge, one transfer in flight.
// Define WB2AV_TIMEOUT_EN to compile in the watchdog that ends hung transfers with wb_err.
module wb2av_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_adr,
    input  logic [DW/8-1:0] wb_sel,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack,
    output logic            wb_err,
    output logic [AW-1:0]   av_address,
    output logic [DW/8-1:0] av_byteenable,
    output logic            av_read,
    output logic            av_write,
    output logic [DW-1:0]   av_writedata,
    input  logic            av_waitrequest,
    input  logic [DW-1:0]   av_readdata,
    input  logic            av_readdatavalid
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   av_address_q, av_address_d;
    logic [SW-1:0]   av_byteenable_q, av_byteenable_d;
    logic [DW-1:0]   av_writedata_q, av_writedata_d;
    logic            av_read_q, av_read_d;
    logic            av_write_q, av_write_d;
    logic [DW-1:0]   wb_dat_o_q, wb_dat_o_d;
    logic            wb_ack_q, wb_ack_d;
    logic            wb_err_q, wb_err_d;
    logic            we_q, we_d;
    logic            abort_q, abort_d;
    logic            timeout;

`ifdef WB2AV_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] count_q, count_d;

    // Counter is zero on the first CMD cycle, so the limit trips after TIMEOUT busy cycles.
    always_comb begin
        count_d = '0;
        if (state_q == CMD || state_q == RDWAIT) begin
            count_d = count_q + 16'd1;
        end
    end

    assign timeout = (count_q + 16'd1) == TIMEOUT_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        av_address_d    = av_address_q;
        av_byteenable_d = av_byteenable_q;
        av_writedata_d  = av_writedata_q;
        av_read_d       = av_read_q;
        av_write_d      = av_write_q;
        wb_dat_o_d      = wb_dat_o_q;
        wb_ack_d        = 1'b0;
        wb_err_d        = 1'b0;
        we_d            = we_q;
        abort_d         = abort_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    av_address_d    = wb_adr;
                    av_byteenable_d = wb_sel;
                    av_writedata_d  = wb_dat_i;
                    av_read_d       = !wb_we;
                    av_write_d      = wb_we;
                    we_d            = wb_we;
                    abort_d         = 1'b0;
                    state_d         = CMD;
                end
            end
            // An issued command cannot be withdrawn, so an abort only suppresses completion.
            CMD: begin
                abort_d = abort_q || !wb_cyc;
                if (!av_waitrequest) begin
                    av_read_d  = 1'b0;
                    av_write_d = 1'b0;
                    if (!we_q) begin
                        state_d = RDWAIT;
                    end else if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        wb_ack_d = 1'b1;
                        state_d  = DONE;
                    end
                end else if (timeout) begin
                    av_read_d  = 1'b0;
                    av_write_d = 1'b0;
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        wb_err_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            RDWAIT: begin
                abort_d = abort_q || !wb_cyc;
                if (av_readdatavalid) begin
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        wb_dat_o_d = av_readdata;
                        wb_ack_d   = 1'b1;
                        state_d    = DONE;
                    end
                end else if (timeout) begin
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        wb_err_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            av_address_q    <= '0;
            av_byteenable_q <= '0;
            av_writedata_q  <= '0;
            av_read_q       <= 1'b0;
            av_write_q      <= 1'b0;
            wb_dat_o_q      <= '0;
            wb_ack_q        <= 1'b0;
            wb_err_q        <= 1'b0;
            we_q            <= 1'b0;
            abort_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            av_address_q    <= av_address_d;
            av_byteenable_q <= av_byteenable_d;
            av_writedata_q  <= av_writedata_d;
            av_read_q       <= av_read_d;
            av_write_q      <= av_write_d;
            wb_dat_o_q      <= wb_dat_o_d;
            wb_ack_q        <= wb_ack_d;
            wb_err_q        <= wb_err_d;
            we_q            <= we_d;
            abort_q         <= abort_d;
        end
    end

    assign av_address    = av_address_q;
    assign av_byteenable = av_byteenable_q;
    assign av_writedata  = av_writedata_q;
    assign av_read       = av_read_q;
    assign av_write      = av_write_q;
    assign wb_dat_o      = wb_dat_o_q;
    assign wb_ack        = wb_ack_q;
    assign wb_err        = wb_err_q;

endmodule

// File: doc/wb2av_bridge.md
# wb2av_bridge

Wishbone B3 classic slave to Avalon-MM pipelined master bridge: the return direction of the existing Avalon-to-Wishbone master bridge. It lets a Wishbone-side initiator, such as the I2C/SoC control path, reach Avalon-MM slaves. Exactly one transaction is in flight at a time. Each Wishbone cycle is converted into a single Avalon read or write command held until `waitrequest` releases; reads then wait for `readdatavalid`. An optional watchdog terminates hung transfers with `wb_err`.

## Interface
Parameters:
- `AW`, default 32: address width on both sides.
- `DW`, default 64: data width, a multiple of 8. `SW = DW/8` is the byte-select width.
- `TIMEOUT`, default 255: watchdog limit in clk cycles, 1..65535. Used only with `WB2AV_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_cyc`  in  1  Wishbone bus cycle.
- `wb_stb`  in  1  Wishbone strobe.
- `wb_we`  in  1  1 = write, 0 = read.
- `wb_adr`  in  AW  byte address.
- `wb_sel`  in  SW  byte selects.
- `wb_dat_i`  in  DW  write data.
- `wb_dat_o`  out  DW  read data, valid with `wb_ack`.
- `wb_ack`  out  1  one-cycle completion pulse.
- `wb_err`  out  1  one-cycle error pulse; tied 0 without `WB2AV_TIMEOUT_EN`.
- `av_address`  out  AW  Avalon address.
- `av_byteenable`  out  SW  Avalon byte enables.
- `av_read`  out  1  Avalon read command.
- `av_write`  out  1  Avalon write command.
- `av_writedata`  out  DW  Avalon write data.
- `av_waitrequest`  in  1  slave stall.
- `av_readdata`  in  DW  read data.
- `av_readdatavalid`  in  1  read data valid.

## Operation
- Reset value of every output is 0. All outputs are registered.
- FSM states are IDLE, CMD, RDWAIT and DONE.
- IDLE:
  - Go to CMD when `wb_cyc & wb_stb` is sampled.
  - On that edge, latch `wb_adr`, `wb_sel` and `wb_dat_i` into the `av_*` registers.
  - Set `av_read = !wb_we` and `av_write = wb_we`.
- CMD:
  - Hold the command and all `av_*` fields stable while `av_waitrequest = 1`.
  - When the command is accepted (`av_waitrequest = 0` at the edge), deassert `av_read`/`av_write`.
  - A write goes to DONE with `wb_ack = 1`.
  - A read goes to RDWAIT.
- RDWAIT:
  - On `av_readdatavalid = 1`, capture `av_readdata` into `wb_dat_o`, set `wb_ack = 1` and go to DONE.
  - If `readdatavalid` is asserted in the same cycle as acceptance (illegal for pipelined slaves), ignore it.
- DONE:
  - `wb_ack`/`wb_err` is high for this single cycle, then the FSM returns to IDLE.
  - `wb_dat_o` holds its value until the next read completes.
  - IDLE does not re-sample until the cycle after DONE, so a master dropping `stb` after `ack` never starts a duplicate transfer.
- Abort (`wb_cyc` falls in CMD or RDWAIT):
  - An Avalon command cannot be withdrawn, so the command is held until accepted and read data is drained.
  - The completion is suppressed: no `wb_ack`, and `wb_dat_o` is not updated. The FSM goes to IDLE.
- `av_readdatavalid` seen in IDLE, CMD or DONE is ignored.
- Asynchronous reset mid-transfer forces IDLE and zeroes all outputs immediately; the Avalon command is dropped.

## Timing
- Wishbone request sampled at edge N (state IDLE).
- `av_read`/`av_write` are high from cycle N+1.
- Write with zero wait: accepted at edge N+1; `wb_ack` is high in cycle N+2, giving 2-cycle latency. Each wait-state cycle adds 1.
- Read with zero wait and `readdatavalid` in cycle N+2: `wb_ack` and `wb_dat_o` in cycle N+3, giving 3-cycle latency.
- Back-to-back throughput: one transfer per latency+1 cycles (the DONE cycle plus the IDLE sample).
- Watchdog counter:
  - 16 bits, cleared on entry to CMD, counting in CMD and RDWAIT.
  - When count == TIMEOUT: deassert `av_read`/`av_write`, pulse `wb_err` (not `wb_ack`) in DONE, go to IDLE.
  - A late `readdatavalid` after a timeout is ignored.

## Configuration
- `WB2AV_TIMEOUT_EN` defined:
  - The watchdog counter and `wb_err` generation are compiled in.
  - An aborted transfer that times out returns to IDLE without `wb_err`.
- `WB2AV_TIMEOUT_EN` undefined:
  - No counter is present; `wb_err` is constant 0.
  - CMD and RDWAIT wait indefinitely.

## Test plan
- Reset: hold `rst_n = 0` with random inputs -> all outputs 0. Release -> FSM in IDLE, no Avalon command.
- Write, `adr = 0x100`, `sel = 0xFF`, `dat = 0xDEADBEEF_01234567`, `waitrequest` high 3 cycles -> `av_write` held 4 cycles with stable fields; `wb_ack` one cycle, 5 cycles after sampling.
- Read at `0x200`, zero wait, `readdatavalid` 2 cycles after acceptance with `readdata = 0xA5A5...` -> `wb_ack` with `wb_dat_o = 0xA5A5...`, 4 cycles after sampling; exactly one `av_read` cycle.
- Abort: `wb_cyc` dropped in RDWAIT -> `readdatavalid` is drained, no `wb_ack`, `wb_dat_o` keeps its previous value, the next transfer proceeds normally.
- Timeout (macro on, `TIMEOUT = 8`): `waitrequest` stuck high -> `av_read` drops and `wb_err` pulses after 8 cycles in CMD; a later spurious `readdatavalid` is ignored.
- Back-to-back: 4 writes with `stb` held after each `ack` -> exactly 4 `av_write` acceptances and 4 `wb_ack` pulses, with no duplicates.
